// File: rtl/demux4_3_hs.sv
// Steers one producer word to one of three consumers through a small in-order FIFO.
// Latency 1 cycle push-to-present, no bypass; head-of-line blocking, in_ready depends only on occupancy.

module demux4_3_hs_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH-1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Callers only push when not full and only pop when not empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
endmodule

module demux4_3_hs #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 selector,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       out_valid_0,
  output logic                       out_valid_1,
  output logic                       out_valid_2,
  input  logic                       out_ready_0,
  input  logic                       out_ready_1,
  input  logic                       out_ready_2,
  output logic [DATA_W-1:0]          data_out_0,
  output logic [DATA_W-1:0]          data_out_1,
  output logic [DATA_W-1:0]          data_out_2,
  output logic                       err_sel,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  typedef struct packed {
    logic [1:0]        dst;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t     push_entry;
  entry_t     head;
  logic [EW-1:0] head_raw;
  logic       sel_bad;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic [2:0] head_vld;
  logic [2:0] cons_rdy;

  // Decode happens once at push so the output side only sees legal destinations.
  always_comb begin
    push_entry.data = data_in;
    push_entry.dst  = 2'd0;
    sel_bad         = 1'b0;
    case (selector)
      3'b000:  push_entry.dst = 2'd0;
      3'b001:  push_entry.dst = 2'd1;
      3'b010:  push_entry.dst = 2'd2;
      default: begin
        push_entry.dst = 2'd0;
        sel_bad        = 1'b1;
      end
    endcase
  end

  // Full blocks acceptance even if the head leaves this cycle: keeps out_ready off the in_ready path.
  assign in_ready = ~reset & ~full;
  assign push     = in_valid & in_ready;

  demux4_3_hs_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_raw),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign head     = entry_t'(head_raw);
  assign cons_rdy = {out_ready_2, out_ready_1, out_ready_0};

  always_comb begin
    head_vld = 3'b000;
    if (!empty) begin
      case (head.dst)
        2'd1:    head_vld = 3'b010;
        2'd2:    head_vld = 3'b100;
        default: head_vld = 3'b001;
      endcase
    end
  end

  assign pop = |(head_vld & cons_rdy);

  assign out_valid_0 = head_vld[0];
  assign out_valid_1 = head_vld[1];
  assign out_valid_2 = head_vld[2];
  assign data_out_0  = head_vld[0] ? head.data : '0;
  assign data_out_1  = head_vld[1] ? head.data : '0;
  assign data_out_2  = head_vld[2] ? head.data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_sel <= 1'b0;
    end else if (push && sel_bad) begin
      err_sel <= 1'b1;
    end
  end
endmodule

// File: tb/tb_demux4_3_hs.sv
// Directed-vector bench for demux4_3_hs: stimulus pushes expected words into a scoreboard,
// a negedge monitor pops and compares every delivered word.

module tb_demux4_3_hs;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        selector;
  logic [DATA_W-1:0] data_in;
  logic [2:0]        ov;
  logic [2:0]        ordy;
  logic [DATA_W-1:0] dout [3];
  logic              err_sel;
  logic [1:0]        count;

  always #5 clk = ~clk;

  demux4_3_hs #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .selector    (selector),
    .data_in     (data_in),
    .out_valid_0 (ov[0]),
    .out_valid_1 (ov[1]),
    .out_valid_2 (ov[2]),
    .out_ready_0 (ordy[0]),
    .out_ready_1 (ordy[1]),
    .out_ready_2 (ordy[2]),
    .data_out_0  (dout[0]),
    .data_out_1  (dout[1]),
    .data_out_2  (dout[2]),
    .err_sel     (err_sel),
    .count       (count)
  );

  typedef struct packed {
    logic [1:0]        port;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;
  logic [2:0]        hold = '0;
  logic [DATA_W-1:0] hold_dat [3];
  time  t0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: delivery order/data, one-hot valid, zeroed idle ports, stable held outputs.
  always @(negedge clk) begin
    if (reset) begin
      hold = '0;
    end else begin
      chk("onehot_vld", 32'($countones(ov) <= 1), 32'd1);
      for (int k = 0; k < 3; k++) begin
        if (hold[k]) begin
          chk($sformatf("hold_vld%0d", k), 32'(ov[k]), 32'd1);
          chk($sformatf("hold_dat%0d", k), dout[k], hold_dat[k]);
        end
        if (!ov[k]) chk($sformatf("idle_dout%0d", k), dout[k], 32'd0);
        if (ov[k] && ordy[k]) begin
          if (sb.size() == 0) begin
            chk($sformatf("unexpected_pop%0d", k), 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("pop_port", 32'(k), 32'(e.port));
            chk("pop_data", dout[k], e.data);
          end
        end
        hold[k]     = ov[k] && !ordy[k];
        hold_dat[k] = dout[k];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid until accepted; returns 1 time unit after the accepting edge, in_valid still high.
  task automatic push(input logic [2:0] sel, input logic [31:0] d, input logic [1:0] port);
    bit ok = 1'b0;
    in_valid = 1'b1;
    selector = sel;
    data_in  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp_t'({port, d}));
        ok = 1'b1;
      end
      step();
    end
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    selector = 3'b111;
    data_in  = 32'hBAD0_BAD0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    selector = 3'b000;
    data_in  = '0;
    ordy     = 3'b000;

    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err_sel", 32'(err_sel), 32'd0);
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_dout1", dout[1], 32'd0);
    step();

    // Single word to consumer 1, one-cycle latency.
    ordy = 3'b010;
    push(3'b001, 32'hDEADBEEF, 2'd1);
    idle();
    @(negedge clk);
    chk("lat_ov", 32'(ov), 32'b010);
    chk("lat_dout1", dout[1], 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("t1_count", 32'(count), 32'd0);
    step();

    // Head-of-line blocking: consumer 2 ready, head is for consumer 0.
    ordy = 3'b000;
    push(3'b000, 32'h11, 2'd0);
    push(3'b010, 32'h22, 2'd2);
    idle();
    @(negedge clk);
    chk("t2_count_full", 32'(count), 32'd2);
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    chk("t2_ov", 32'(ov), 32'b001);
    chk("t2_dout0", dout[0], 32'h11);
    step();
    ordy = 3'b100;
    @(negedge clk);
    chk("hol_count_a", 32'(count), 32'd2);
    step();
    @(negedge clk);
    chk("hol_count_b", 32'(count), 32'd2);
    step();
    ordy = 3'b101;
    step();
    step();
    @(negedge clk);
    chk("t2_drained", 32'(count), 32'd0);
    step();

    // Undefined selector goes to port 0 and sets the sticky flag.
    ordy = 3'b111;
    push(3'b101, 32'h55, 2'd0);
    idle();
    @(negedge clk);
    chk("bad_sel_ov", 32'(ov), 32'b001);
    chk("bad_sel_dout0", dout[0], 32'h55);
    chk("err_sel_set", 32'(err_sel), 32'd1);
    step();
    push(3'b000, 32'h66, 2'd0);
    push(3'b001, 32'h77, 2'd1);
    idle();
    step();
    step();
    @(negedge clk);
    chk("err_sel_sticky", 32'(err_sel), 32'd1);
    chk("t3_count", 32'(count), 32'd0);
    step();

    // Full FIFO with a pop in the same cycle: push waits one cycle (count 2->1->2).
    ordy = 3'b000;
    push(3'b001, 32'hA1, 2'd1);
    push(3'b010, 32'hA2, 2'd2);
    selector = 3'b000;
    data_in  = 32'hA3;
    ordy     = 3'b010;
    @(negedge clk);
    chk("full_count", 32'(count), 32'd2);
    chk("full_no_push", 32'(in_ready), 32'd0);
    step();
    @(negedge clk);
    chk("after_pop_count", 32'(count), 32'd1);
    chk("after_pop_in_ready", 32'(in_ready), 32'd1);
    if (in_ready) sb.push_back(exp_t'({2'd0, 32'hA3}));
    step();
    idle();
    @(negedge clk);
    chk("refill_count", 32'(count), 32'd2);
    step();
    ordy = 3'b111;
    repeat (3) step();
    @(negedge clk);
    chk("t4_drained", 32'(count), 32'd0);
    step();

    // Streaming, one word per cycle across several pointer wraps.
    ordy = 3'b111;
    t0 = $time;
    for (int i = 0; i < 9; i++) push(3'(i % 3), 32'(256 + i), 2'(i % 3));
    chk("stream_cycles", 32'(($time - t0) / 10), 32'd9);
    idle();
    @(negedge clk);
    chk("stream_count_tail", 32'(count), 32'd1);
    step();
    @(negedge clk);
    chk("stream_drained", 32'(count), 32'd0);
    step();

    // Reset while full with consumer 1 stalled.
    ordy = 3'b000;
    push(3'b001, 32'hB1, 2'd1);
    push(3'b001, 32'hB2, 2'd1);
    idle();
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 32'd2);
    chk("pre_rst_ov", 32'(ov), 32'b010);
    step();
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rst2_in_ready", 32'(in_ready), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_ov", 32'(ov), 32'd0);
    chk("rst2_count", 32'(count), 32'd0);
    chk("rst2_err_sel", 32'(err_sel), 32'd0);
    chk("rst2_dout1", dout[1], 32'd0);
    chk("rst2_in_ready_up", 32'(in_ready), 32'd1);
    step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/demux4_3_hs.md
Name: demux4_3_hs

Overview:
- Steering block, the opposite direction of the datapath 3-input selector mux: takes one 32-bit source word plus a 3-bit destination code and delivers it to one of three consumers.
- Uses a valid/ready handshake on both sides, with a small in-order FIFO so the producer is decoupled from slow consumers.
- Sits between a single producer (e.g., ALU/memory result path) and three destination register/unit interfaces in the multicycle datapath.

Parameters:
- DATA_W, 32: width of data words.
- DEPTH, 2: FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word this cycle.
- selector  input  3  destination code for data_in.
- data_in  input  DATA_W  word to deliver.
- out_valid_0 / out_valid_1 / out_valid_2  output  1 each  head word is addressed to that consumer.
- out_ready_0 / out_ready_1 / out_ready_2  input  1 each  consumer accepts.
- data_out_0 / data_out_1 / data_out_2  output  DATA_W each  head word for that consumer.
- err_sel  output  1  sticky flag: a word with an undefined code was accepted.
- count  output  clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high: reset is sampled on the rising edge of clk, and when high it overrides all other activity.
- Reset values:
  - FIFO pointers = 0; count = 0; err_sel = 0; in_ready = 0 during the reset cycle.
  - All out_valid_k = 0; all data_out_k = 0.
  - FIFO storage contents are don't-care.
- Reset mid-operation: all buffered words are discarded and no out_valid_k is asserted in the following cycle. in_ready = 1 from the first cycle after reset deasserts.
- Destination decode, performed at push: 000→0, 001→1, 010→2. Any other code (011–111)→0, and err_sel is set to 1 on that push. err_sel stays 1 until reset.
- Each FIFO entry holds a 2-bit decoded destination and DATA_W of data.
- Push: occurs when in_valid && in_ready. in_ready = (count != DEPTH), registered-state only; there is no combinational path from out_ready_k to in_ready. When full, in_ready = 0 even if a pop happens in the same cycle.
- Head presentation:
  - If count != 0, out_valid_k = 1 only for k == head destination; the other two are 0.
  - data_out_k = head data when out_valid_k = 1, else 0.
  - Outputs are driven from registered state, not from the inputs of the current cycle.
- Pop: occurs when out_valid_k && out_ready_k for the addressed k. out_ready of non-addressed consumers is ignored.
- Latency: a word pushed at edge N appears as out_valid at the cycle following edge N (one cycle minimum). There is no bypass path when the FIFO is empty.
- Ordering is strict FIFO with head-of-line blocking: a stalled consumer blocks the words behind it, even words for other consumers.
- Handshake stability: while out_valid_k && !out_ready_k, out_valid_k and data_out_k hold constant.
- Producer rule: in_valid and selector/data_in may change freely while in_ready = 0; they are sampled only on a push.
- Simultaneous push and pop (count not 0 and not DEPTH): count unchanged, both pointers advance.
- Pointer wrap: read and write pointers wrap from DEPTH-1 to 0.
- count range is 0..DEPTH; it never overflows or underflows.

Test Plan:
- Reset, then push {sel=001, data=0xDEADBEEF} with out_ready_1=1 → next cycle out_valid_1=1, data_out_1=0xDEADBEEF, out_valid_0/2=0 → popped, count back to 0.
- Push sel=000 0x11, sel=010 0x22 back-to-back with all out_ready=0 → count=2, in_ready=0 → raise out_ready_2 only: no pop (head is dest 0) → raise out_ready_0: 0x11 pops, then 0x22 pops in order.
- Push sel=101, data=0x55 → delivered on port 0 with data_out_0=0x55; err_sel=1 and stays 1 after further valid pushes until reset.
- Full FIFO (count=2), pop in same cycle as in_valid=1 → no push that cycle (in_ready=0); push succeeds next cycle; count sequence 2→1→2.
- Continuous streaming: in_valid=1 every cycle with sel cycling 000/001/010, all out_ready=1 → one word per cycle after a 1-cycle fill, data order preserved, pointers wrap correctly over ≥8 words.
- Assert reset with count=2 and out_valid_1 held high → next cycle all out_valid=0, count=0, err_sel=0, data_out_k=0.
